// File: rtl/pc_unit.sv
// Program counter with prioritized redirect/halt/stall/increment selection and a RUN/HALTED FSM.
// Misaligned redirects are rejected and flagged for one cycle; increment overflow is flagged for one cycle.
module pc_unit #(
   parameter int                 WIDTH      = 32,
   parameter int                 STEP       = 4,
   parameter logic [WIDTH-1:0]   RESET_VEC  = '0,
   parameter int                 ALIGN_BITS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             halt,
   input  logic             resume,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jmp,
   input  logic [WIDTH-1:0] jmp_target,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_next,
   output logic             pc_valid,
   output logic             wrap,
   output logic             misalign
);

   typedef enum logic {
      S_RUN    = 1'b0,
      S_HALTED = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
   localparam logic [WIDTH:0]   STEP_EXT   = (WIDTH+1)'(STEP);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             wrap_q, wrap_d;
   logic             misalign_q, misalign_d;

   logic [WIDTH:0]   inc_sum;
   logic [WIDTH-1:0] redir_target;
   logic             redir_req;
   logic             redir_aligned;

   // The extra top bit of the sum is the carry out that signals wrap.
   assign inc_sum       = {1'b0, pc_q} + STEP_EXT;
   // jmp fully shadows br_taken, even when the jump target is rejected.
   assign redir_req     = jmp | br_taken;
   assign redir_target  = jmp ? jmp_target : br_target;
   assign redir_aligned = ((redir_target & ALIGN_MASK) == '0);

   always_comb begin
      pc_d       = pc_q;
      state_d    = state_q;
      wrap_d     = 1'b0;
      misalign_d = 1'b0;
      if (rst) begin
         pc_d    = RESET_VEC;
         state_d = S_RUN;
      end else if (redir_req) begin
         if (redir_aligned) begin
            pc_d = redir_target;
         end else begin
            misalign_d = 1'b1;
         end
      end else if (state_q == S_HALTED) begin
         if (resume && !halt) begin
            state_d = S_RUN;
         end
      end else if (halt) begin
         state_d = S_HALTED;
      end else if (!stall) begin
         pc_d   = inc_sum[WIDTH-1:0];
         wrap_d = inc_sum[WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_VEC;
         state_q    <= S_RUN;
         wrap_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         state_q    <= state_d;
         wrap_q     <= wrap_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc       = pc_q;
   assign pc_next  = pc_d;
   assign pc_valid = (state_q == S_RUN);
   assign wrap     = wrap_q;
   assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random traffic, all checked against an arithmetic model.
module tb_pc_unit;
   localparam int     W    = 32;
   localparam longint STEP = 4;
   localparam longint MOD  = 64'h1_0000_0000;

   logic         clk = 1'b0;
   logic         rst = 1'b0, stall = 1'b0, halt = 1'b0, resume = 1'b0;
   logic         br_taken = 1'b0, jmp = 1'b0;
   logic [W-1:0] br_target = '0, jmp_target = '0;
   logic [W-1:0] pc, pc_next;
   logic         pc_valid, wrap, misalign;

   int total = 0;
   int bad   = 0;

   // Reference state: the architectural PC as an unbounded integer reduced modulo 2^32.
   longint m_pc = 0;
   bit     m_halted = 0, m_wrap = 0, m_mis = 0;
   longint n_pc = 0;
   bit     n_halted = 0, n_wrap = 0, n_mis = 0;

   pc_unit #(.WIDTH(W), .STEP(4), .RESET_VEC('0), .ALIGN_BITS(2)) dut (
      .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
      .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
      .pc(pc), .pc_next(pc_next), .pc_valid(pc_valid), .wrap(wrap), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void predict();
      longint tgt;
      longint s;
      n_pc = m_pc; n_halted = m_halted; n_wrap = 0; n_mis = 0;
      if (rst) begin
         n_pc = 0; n_halted = 0;
         return;
      end
      tgt = jmp ? longint'(jmp_target) : longint'(br_target);
      if (jmp || br_taken) begin
         if (tgt % 4 == 0) n_pc = tgt;
         else n_mis = 1;
      end else if (m_halted) begin
         if (resume && !halt) n_halted = 0;
      end else if (halt) begin
         n_halted = 1;
      end else if (!stall) begin
         s      = m_pc + STEP;
         n_wrap = (s >= MOD);
         n_pc   = s % MOD;
      end
   endfunction

   task automatic drive(input bit r, input bit j, input logic [W-1:0] jt, input bit b,
                        input logic [W-1:0] bt, input bit h, input bit rs, input bit s);
      rst = r; jmp = j; jmp_target = jt; br_taken = b; br_target = bt;
      halt = h; resume = rs; stall = s;
   endtask

   task automatic idle();
      drive(0, 0, '0, 0, '0, 0, 0, 0);
   endtask

   task automatic tick(input string tag);
      #2;
      predict();
      check({tag, "/pc_next"}, pc_next, n_pc);
      @(posedge clk);
      #1;
      m_pc = n_pc; m_halted = n_halted; m_wrap = n_wrap; m_mis = n_mis;
      check({tag, "/pc"}, pc, m_pc);
      check({tag, "/pc_valid"}, pc_valid, !m_halted);
      check({tag, "/wrap"}, wrap, m_wrap);
      check({tag, "/misalign"}, misalign, m_mis);
      $display("cycle %s: pc=%h pc_valid=%0b wrap=%0b misalign=%0b", tag, pc, pc_valid, wrap, misalign);
   endtask

   function automatic logic [W-1:0] rnd_target();
      logic [W-1:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      return t;
   endfunction

   initial begin
      @(posedge clk);
      #1;
      // Reset and free-running sequence.
      drive(1, 0, '0, 0, '0, 0, 0, 0); tick("reset");
      check("reset/pc_const", pc, 0);
      check("reset/valid_const", pc_valid, 1);
      idle();
      tick("free1"); check("free1/pc_const", pc, 32'h4);
      tick("free2"); check("free2/pc_const", pc, 32'h8);
      tick("free3"); check("free3/pc_const", pc, 32'hC);
      tick("free4"); check("free4/pc_const", pc, 32'h10);

      // jmp beats br_taken, then a misaligned branch is rejected.
      drive(0, 1, 32'h100, 1, 32'h200, 0, 0, 0); tick("jmp_vs_br");
      check("jmp_vs_br/pc_const", pc, 32'h100);
      drive(0, 0, '0, 1, 32'h202, 0, 0, 0); tick("br_misalign");
      check("br_misalign/pc_const", pc, 32'h100);
      check("br_misalign/flag_const", misalign, 1);
      idle(); tick("post_misalign");
      check("post_misalign/flag_const", misalign, 0);

      // Misaligned jmp shadows an aligned branch.
      drive(0, 1, 32'h301, 1, 32'h400, 0, 0, 0); tick("jmp_bad_br_ok");
      check("jmp_bad_br_ok/pc_const", pc, 32'h104);

      // Wrap at the top of the address space.
      drive(0, 1, 32'hFFFF_FFFC, 0, '0, 0, 0, 0); tick("to_top");
      idle(); tick("wrap");
      check("wrap/pc_const", pc, 0);
      check("wrap/flag_const", wrap, 1);
      tick("after_wrap");
      check("after_wrap/flag_const", wrap, 0);

      // Halt, stall toggling while halted, simultaneous halt+resume, then resume.
      drive(0, 1, 32'h40, 0, '0, 0, 0, 0); tick("to_40");
      drive(0, 0, '0, 0, '0, 1, 0, 0); tick("halt");
      check("halt/valid_const", pc_valid, 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, '0, 0, '0, 0, 0, i[0]); tick("halted_stall");
         check("halted_stall/pc_const", pc, 32'h40);
      end
      drive(0, 0, '0, 0, '0, 1, 1, 0); tick("halt_and_resume");
      check("halt_and_resume/valid_const", pc_valid, 0);
      drive(0, 0, '0, 0, '0, 0, 1, 0); tick("resume");
      check("resume/valid_const", pc_valid, 1);
      check("resume/pc_const", pc, 32'h40);
      idle(); tick("resume_inc");
      check("resume_inc/pc_const", pc, 32'h44);

      // Redirect while halted, then reset overriding a jump.
      drive(0, 0, '0, 0, '0, 1, 0, 0); tick("halt2");
      drive(0, 1, 32'h80, 0, '0, 0, 0, 0); tick("halted_jmp");
      check("halted_jmp/pc_const", pc, 32'h80);
      check("halted_jmp/valid_const", pc_valid, 0);
      drive(1, 1, 32'h80, 0, '0, 1, 0, 1); tick("rst_over_jmp");
      check("rst_over_jmp/pc_const", pc, 0);
      check("rst_over_jmp/valid_const", pc_valid, 1);

      // Stall holds pc and pc_next.
      drive(0, 1, 32'h20, 0, '0, 0, 0, 0); tick("to_20");
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, '0, 0, '0, 0, 0, 1);
         #1 check("stall/pc_next_const", pc_next, 32'h20);
         tick("stall");
         check("stall/pc_const", pc, 32'h20);
      end
      idle();
      #1 check("unstall/pc_next_const", pc_next, 32'h24);
      tick("unstall");

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, rnd_target(),
               $urandom_range(0, 7) == 0, rnd_target(), $urandom_range(0, 9) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
         tick("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
